// File: rtl/wb_pkg.sv
// Shared defaults for the 4-bit write-back slice: widths, register count and a
// constant-time log2 helper used to size register addresses.
package wb_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int WB_WIDTH   = 4;
  localparam int WB_NREGS   = 4;
  localparam int WB_ADDR_W  = clog2(WB_NREGS);
  localparam int WB_CNT_W   = 8;
  localparam bit WB_R0_ZERO = 1'b1;

endpackage

// File: rtl/regfile_4x4b.sv
// Small register array: one synchronous write port (r0 optionally hard-wired
// to zero) and two asynchronous read ports.
module regfile_4x4b
  import wb_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int NREGS   = WB_NREGS,
  parameter int ADDR_W  = clog2(NREGS),
  parameter bit R0_ZERO = WB_R0_ZERO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && !(R0_ZERO && waddr == '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_stage_4b.sv
// Write-back stage: holds one result for a cycle, commits it to the register
// file, and forwards the pending entry to both read ports.
module wb_stage_4b
  import wb_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int NREGS   = WB_NREGS,
  parameter int CNT_W   = WB_CNT_W,
  parameter bit R0_ZERO = WB_R0_ZERO,
  localparam int ADDR_W = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  wr_count
);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;
  logic              accept;
  logic              commit;
  logic [WIDTH-1:0]  rf_data_a;
  logic [WIDTH-1:0]  rf_data_b;

  assign in_ready = !stall;
  assign accept   = in_valid && in_ready && in_we;
  assign commit   = wb_valid && !stall;

  // Writes aimed at a hard-wired r0 enter the stage as bubbles so they never commit or count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (accept) begin
      wb_valid <= !(R0_ZERO && in_rd == '0);
      wb_rd    <= in_rd;
      wb_data  <= in_result;
    end else if (!stall) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
      wr_count  <= '0;
    end else if (commit) begin
      zero_flag <= (wb_data == '0);
      wr_count  <= wr_count + CNT_W'(1);
    end
  end

  regfile_4x4b #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rd_addr_a),
    .rdata_a (rf_data_a),
    .raddr_b (rd_addr_b),
    .rdata_b (rf_data_b)
  );

  // The pending entry is newer than the array, so it wins over the stored value.
  always_comb begin
    rd_data_a = rf_data_a;
    rd_data_b = rf_data_b;
    if (R0_ZERO && rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wb_valid && wb_rd == rd_addr_a) begin
      rd_data_a = wb_data;
    end
    if (R0_ZERO && rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wb_valid && wb_rd == rd_addr_b) begin
      rd_data_b = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_stage_4b.sv
// Scoreboard bench for wb_stage_4b: directed vectors push per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_stage_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [1:0] in_rd;
  logic       in_we;
  logic       stall;
  logic [1:0] rd_addr_a;
  logic [3:0] rd_data_a;
  logic [1:0] rd_addr_b;
  logic [3:0] rd_data_b;
  logic       zero_flag;
  logic [7:0] wr_count;

  typedef struct {
    int    cyc;
    string name;
    int    a;
    int    b;
    int    z;
    int    c;
    int    r;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  wb_stage_4b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .stall     (stall),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .zero_flag (zero_flag),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic we,
                               input logic [3:0] res, input logic [1:0] rd,
                               input logic st, input logic [1:0] aa,
                               input logic [1:0] ab);
    rst       = r;
    in_valid  = v;
    in_we     = we;
    in_result = res;
    in_rd     = rd;
    stall     = st;
    rd_addr_a = aa;
    rd_addr_b = ab;
  endtask

  // Expected values for the current cycle; -1 means that output is not checked.
  task automatic checkOutput(input string name, input int a, input int b,
                             input int z, input int c, input int r);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.a    = a;
    e.b    = b;
    e.z    = z;
    e.c    = c;
    e.r    = r;
    sb.push_back(e);
  endtask

  task automatic compareField(input string name, input string field,
                              input logic [7:0] act, input int want);
    if (want >= 0) begin
      checks = checks + 1;
      if (act !== want[7:0]) begin
        errors = errors + 1;
        $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, want[7:0]);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("[TB] FAIL %s.stale actual=%0d expected=%0d", e.name, cyc, e.cyc);
        end else begin
          compareField(e.name, "rd_data_a", {4'b0, rd_data_a}, e.a);
          compareField(e.name, "rd_data_b", {4'b0, rd_data_b}, e.b);
          compareField(e.name, "zero_flag", {7'b0, zero_flag}, e.z);
          compareField(e.name, "wr_count", wr_count, e.c);
          compareField(e.name, "in_ready", {7'b0, in_ready}, e.r);
        end
      end
    end
  end

  initial begin : stimulus
    applyStimulus(1, 0, 0, 4'h0, 2'd0, 0, 2'd0, 2'd0);
    tick();
    checkOutput("rst_ready", -1, -1, -1, -1, 1);
    tick();
    applyStimulus(1, 0, 0, 4'h0, 2'd0, 1, 2'd0, 2'd0);
    checkOutput("rst_stall_ready", -1, -1, -1, -1, 0);
    tick();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'(i), 2'(3 - i));
      checkOutput("reset_read", 0, 0, 0, 0, 1);
      tick();
    end

    applyStimulus(0, 1, 1, 4'b1000 | 4'b1001, 2'd1, 0, 2'd1, 2'd2);
    checkOutput("t2_pre", 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 1, 1, 4'b1101 | 4'b0110, 2'd2, 0, 2'd1, 2'd2);
    checkOutput("t2_bypass1", 9, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd1, 2'd2);
    checkOutput("t2_bypass2", 9, 15, 0, 1, 1);
    tick();
    checkOutput("t2_commit", 9, 15, 0, 2, 1);
    tick();

    applyStimulus(0, 1, 1, 4'b0000, 2'd3, 0, 2'd3, 2'd1);
    checkOutput("t3_pre", 0, 9, 0, 2, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd3, 2'd1);
    checkOutput("t3_bypass", 0, 9, 0, 2, 1);
    tick();
    checkOutput("t3_zero_commit", 0, 9, 1, 3, 1);
    tick();
    applyStimulus(0, 1, 1, 4'b0101, 2'd0, 0, 2'd0, 2'd2);
    checkOutput("t3_r0_pre", 0, 15, 1, 3, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd0, 2'd2);
    checkOutput("t3_r0_bypass", 0, 15, 1, 3, 1);
    tick();
    checkOutput("t3_r0_dropped", 0, 15, 1, 3, 1);
    tick();

    applyStimulus(0, 1, 1, 4'b0110, 2'd1, 0, 2'd1, 2'd3);
    checkOutput("t4_pre", 9, 0, 1, 3, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 4'b1111, 2'd3, 1, 2'd1, 2'd3);
      checkOutput("t4_stall", 6, 0, 1, 3, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd1, 2'd3);
    checkOutput("t4_release", 6, 0, 1, 3, 1);
    tick();
    checkOutput("t4_commit", 6, 0, 0, 4, 1);
    tick();

    applyStimulus(0, 1, 1, 4'b0011, 2'd2, 0, 2'd2, 2'd2);
    checkOutput("t5_pre", 15, 15, 0, 4, 1);
    tick();
    applyStimulus(0, 1, 1, 4'b1100, 2'd2, 0, 2'd2, 2'd2);
    checkOutput("t5_first", 3, 3, 0, 4, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd2, 2'd2);
    checkOutput("t5_second", 12, 12, 0, 5, 1);
    tick();
    checkOutput("t5_final", 12, 12, 0, 6, 1);
    tick();
    applyStimulus(0, 1, 0, 4'b0000, 2'd2, 0, 2'd2, 2'd0);
    checkOutput("t5_nowe", 12, 0, 0, 6, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd2, 2'd0);
    checkOutput("t5_nowe_after", 12, 0, 0, 6, 1);
    tick();
    checkOutput("t5_nowe_settled", 12, 0, 0, 6, 1);
    tick();

    applyStimulus(0, 1, 1, 4'b1010, 2'd1, 0, 2'd1, 2'd2);
    checkOutput("t6_pre", 6, 12, 0, 6, 1);
    tick();
    applyStimulus(1, 0, 0, 4'h0, 2'd0, 0, 2'd1, 2'd2);
    checkOutput("t6_rst_bypass", 10, 12, 0, 6, 1);
    tick();
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd1, 2'd2);
    checkOutput("t6_after_rst", 0, 0, 0, 0, 1);
    tick();
    checkOutput("t6_no_commit", 0, 0, 0, 0, 1);
    tick();

    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1, 1, 4'(k), 2'd1, 0, 2'd1, 2'd0);
      checkOutput("wrap_stream", (k == 0) ? 0 : ((k - 1) & 15), 0,
                  (k >= 2) ? int'(((k - 2) & 15) == 0) : 0,
                  (k >= 1) ? (k - 1) : 0, 1);
      tick();
    end
    applyStimulus(0, 0, 0, 4'h0, 2'd0, 0, 2'd1, 2'd0);
    checkOutput("wrap_255", 15, 0, 0, 255, 1);
    tick();
    checkOutput("wrap_zero", 15, 0, 0, 0, 1);
    tick();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL drain actual=%0d expected=0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
